// File: rtl/button_int_src.sv
// Push-button interrupt source: synchronises and debounces four active-low buttons,
// latches presses as pending requests and hands them to the CPU one at a time.
module button_int_src #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] buttons_n,
  input  logic       cpu_int_state,
  output logic [3:0] buttons_pressed,
  output logic [3:0] pending,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       r_meta_n;
  logic [3:0]       r_sync_n;
  logic [3:0]       w_sync;
  logic [3:0]       r_stable;
  logic [3:0]       r_stable_d;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       w_press;
  logic [3:0]       w_clr;
  logic [3:0]       r_pending;
  logic             r_overrun;
  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_next;
  logic [3:0]       r_bp;
  logic [3:0]       w_bp_next;

  function automatic logic [1:0] hi_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Synchroniser flops idle at 1 so a released button reads as inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta_n <= 4'b1111;
      r_sync_n <= 4'b1111;
    end else begin
      r_meta_n <= buttons_n;
      r_sync_n <= r_meta_n;
    end
  end

  assign w_sync = ~r_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable   <= 4'b0000;
      r_stable_d <= 4'b0000;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_stable_d <= r_stable;
      for (int i = 0; i < 4; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_stable[i] <= w_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_stable & ~r_stable_d;

  // A press landing on the bit being acknowledged survives: set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 4'b0000;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_press;
      if (|(w_press & r_pending)) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_bp    <= 4'b0000;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_bp    <= w_bp_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_bp_next    = r_bp;
    w_clr        = 4'b0000;
    case (r_state)
      IDLE: begin
        if (|r_pending && !cpu_int_state) begin
          w_sel_next   = hi_idx(r_pending);
          w_bp_next    = 4'b0001 << hi_idx(r_pending);
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (cpu_int_state) begin
          w_clr        = 4'b0001 << r_sel;
          w_bp_next    = 4'b0000;
          w_state_next = SERVICE;
        end
      end
      SERVICE: begin
        w_bp_next = 4'b0000;
        if (!cpu_int_state) w_state_next = IDLE;
      end
      default: begin
        w_bp_next    = 4'b0000;
        w_state_next = IDLE;
      end
    endcase
  end

  assign buttons_pressed = r_bp;
  assign pending         = r_pending;
  assign overrun         = r_overrun;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_button_int_src.sv
// Self-checking bench for button_int_src with a short debounce window.
module tb_button_int_src;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] buttons_n;
  logic       cpu_int_state;
  logic [3:0] buttons_pressed;
  logic [3:0] pending;
  logic       overrun;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {buttons_pressed, pending, overrun}, pushed when driven, popped after the edge.
  logic [8:0] exp_q[$];

  typedef struct {
    logic [3:0] bn;
    logic       cpu;
    logic [3:0] bp;
    logic [3:0] pend;
    logic       ovr;
  } vec_t;

  vec_t t1[12];

  always #5 clk = ~clk;

  button_int_src #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .buttons_n       (buttons_n),
    .cpu_int_state   (cpu_int_state),
    .buttons_pressed (buttons_pressed),
    .pending         (pending),
    .overrun         (overrun),
    .dbg_state       (dbg_state)
  );

  task automatic check_outputs(input string name);
    logic [8:0] exp_v;
    logic [8:0] act_v;
    exp_v = exp_q.pop_front();
    act_v = {buttons_pressed, pending, overrun};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got bp=%b pend=%b ovr=%b, want bp=%b pend=%b ovr=%b",
               name, act_v[8:5], act_v[4:1], act_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    n_tests++;
    if ($countones(buttons_pressed) > 1) begin
      n_fail++;
      $display("FAIL %s_onehot: got bp=%b, want at most one bit set", name, buttons_pressed);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp_s);
    n_tests++;
    if (dbg_state !== exp_s) begin
      n_fail++;
      $display("FAIL %s_state: got %0d, want %0d", name, dbg_state, exp_s);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
  task automatic step(input string name, input logic [3:0] bn, input logic cpu,
                      input logic [3:0] ebp, input logic [3:0] epend, input logic eovr);
    buttons_n     = bn;
    cpu_int_state = cpu;
    exp_q.push_back({ebp, epend, eovr});
    @(negedge clk);
    check_outputs(name);
  endtask

  task automatic do_reset(input string name);
    rst_n         = 1'b0;
    buttons_n     = 4'b1111;
    cpu_int_state = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(9'd0);
    check_outputs(name);
    check_state(name, 2'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset("reset0");

    // Single press of button 1, acknowledged after two cycles of request.
    for (int i = 0; i < 6; i++) t1[i] = '{4'b1101, 1'b0, 4'b0000, 4'b0000, 1'b0};
    t1[6]  = '{4'b1101, 1'b0, 4'b0000, 4'b0010, 1'b0};
    t1[7]  = '{4'b1101, 1'b0, 4'b0010, 4'b0010, 1'b0};
    t1[8]  = '{4'b1101, 1'b0, 4'b0010, 4'b0010, 1'b0};
    t1[9]  = '{4'b1101, 1'b1, 4'b0000, 4'b0000, 1'b0};
    t1[10] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    t1[11] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0};
    for (int i = 0; i < 12; i++)
      step($sformatf("single_e%0d", i + 1), t1[i].bn, t1[i].cpu, t1[i].bp, t1[i].pend, t1[i].ovr);
    check_state("single_end", 2'd0);

    // Bounce on button 0 with 2-cycle phases never completes a debounce window.
    do_reset("reset_bounce");
    for (int i = 0; i < 20; i++)
      step($sformatf("bounce_%0d", i), (i % 4 < 2) ? 4'b1110 : 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++)
      step($sformatf("bounce_rel_%0d", i), 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Buttons 0 and 2 together: 2 wins, 0 follows two edges after the CPU drops.
    do_reset("reset_prio");
    for (int i = 0; i < 6; i++)
      step($sformatf("prio_e%0d", i + 1), 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("prio_e7",  4'b1010, 1'b0, 4'b0000, 4'b0101, 1'b0);
    step("prio_e8",  4'b1010, 1'b0, 4'b0100, 4'b0101, 1'b0);
    step("prio_e9",  4'b1010, 1'b0, 4'b0100, 4'b0101, 1'b0);
    step("prio_ack", 4'b1010, 1'b1, 4'b0000, 4'b0001, 1'b0);
    check_state("prio_ack", 2'd2);
    step("prio_fall1", 4'b1010, 1'b0, 4'b0000, 4'b0001, 1'b0);
    step("prio_fall2", 4'b1010, 1'b0, 4'b0001, 4'b0001, 1'b0);
    step("prio_hold",  4'b1010, 1'b0, 4'b0001, 4'b0001, 1'b0);
    step("prio_ack2",  4'b1010, 1'b1, 4'b0000, 4'b0000, 1'b0);
    step("prio_done1", 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("prio_done2", 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Press while the CPU is already servicing: request waits for the fall.
    do_reset("reset_busy");
    for (int i = 0; i < 6; i++)
      step($sformatf("busy_e%0d", i + 1), 4'b0111, 1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++)
      step($sformatf("busy_wait%0d", i), 4'b0111, 1'b1, 4'b0000, 4'b1000, 1'b0);
    check_state("busy_wait", 2'd0);
    step("busy_fall", 4'b0111, 1'b0, 4'b1000, 4'b1000, 1'b0);
    step("busy_hold", 4'b0111, 1'b0, 4'b1000, 4'b1000, 1'b0);

    // Re-press of button 2 while its request is outstanding sets overrun only.
    do_reset("reset_ovr");
    for (int i = 0; i < 6; i++)
      step($sformatf("ovr_e%0d", i + 1), 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("ovr_e7", 4'b1011, 1'b0, 4'b0000, 4'b0100, 1'b0);
    step("ovr_e8", 4'b1011, 1'b0, 4'b0100, 4'b0100, 1'b0);
    for (int i = 9; i <= 14; i++)
      step($sformatf("ovr_rel_e%0d", i), 4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b0);
    for (int i = 15; i <= 20; i++)
      step($sformatf("ovr_rep_e%0d", i), 4'b1011, 1'b0, 4'b0100, 4'b0100, 1'b0);
    step("ovr_set",   4'b1011, 1'b0, 4'b0100, 4'b0100, 1'b1);
    step("ovr_ack",   4'b1011, 1'b1, 4'b0000, 4'b0000, 1'b1);
    step("ovr_fall1", 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b1);
    step("ovr_fall2", 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b1);
    step("ovr_fall3", 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b1);

    // Asynchronous reset in REQ, then a full debounce before the next request.
    do_reset("reset_mid");
    for (int i = 0; i < 6; i++)
      step($sformatf("mid_e%0d", i + 1), 4'b1101, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("mid_e7", 4'b1101, 1'b0, 4'b0000, 4'b0010, 1'b0);
    step("mid_e8", 4'b1101, 1'b0, 4'b0010, 4'b0010, 1'b0);
    check_state("mid_req", 2'd1);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(9'd0);
    check_outputs("mid_async");
    check_state("mid_async", 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      step($sformatf("mid_re_e%0d", i + 1), 4'b1101, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("mid_re_e7", 4'b1101, 1'b0, 4'b0000, 4'b0010, 1'b0);
    step("mid_re_e8", 4'b1101, 1'b0, 4'b0010, 4'b0010, 1'b0);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
